// File: rtl/sb_rx_deser_if.sv
// sb_rx_deser_if: sideband RX pad/FIFO signal bundle for the deserializer
interface sb_rx_deser_if #(parameter int PKT_WIDTH = 64);
  logic                 i_bit;
  logic                 i_bit_valid;
  logic                 i_fifo_full;
  logic [PKT_WIDTH-1:0] o_packet;
  logic                 o_wr_en;
  logic                 o_rx_active;
  logic                 o_frame_err;
  logic                 o_overflow;
  logic                 o_parity_err;
  modport master(
    output i_bit, i_bit_valid, i_fifo_full,
    input  o_packet, o_wr_en, o_rx_active, o_frame_err, o_overflow, o_parity_err
  );
  modport slave(
    input  i_bit, i_bit_valid, i_fifo_full,
    output o_packet, o_wr_en, o_rx_active, o_frame_err, o_overflow, o_parity_err
  );
endinterface

// File: rtl/sb_rx_deser_fsm.sv
// sb_rx_deser_fsm: sideband RX framing FSM (serial bits -> 64-bit packets, gap check); SB_RX_PARITY_CHK_EN enables packet parity check
module sb_rx_deser_fsm #(
  parameter int PKT_WIDTH = 64,
  parameter int MIN_GAP   = 32,
  parameter int CNT_W     = 7
) (
  input logic          i_clk,
  input logic          i_rst,
  sb_rx_deser_if.slave bus
);
  localparam int IW = $clog2(PKT_WIDTH);
  typedef enum logic [1:0] {IDLE, RECEIVE, GAP} state_t;
  state_t               r_state, w_next;
  logic [PKT_WIDTH-1:0] r_shift, w_shift;
  logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt, r_gap_cnt, w_gap_cnt;
  logic                 w_done, w_ferr, w_par_bad;
  logic                 r_done, r_full, r_par_bad;
`ifdef SB_RX_PARITY_CHK_EN
  assign w_par_bad = bus.i_bit != ^r_shift[PKT_WIDTH-2:0];
`else
  assign w_par_bad = 1'b0;
`endif
  always_comb begin
    w_next    = r_state;
    w_shift   = r_shift;
    w_bit_cnt = r_bit_cnt;
    w_gap_cnt = r_gap_cnt;
    w_done    = 1'b0;
    w_ferr    = 1'b0;
    case (r_state)
      IDLE: if (bus.i_bit_valid) begin
        w_shift[0] = bus.i_bit;
        w_bit_cnt  = CNT_W'(1);
        w_next     = RECEIVE;
      end
      RECEIVE: if (bus.i_bit_valid) begin
        w_shift[r_bit_cnt[IW-1:0]] = bus.i_bit;
        w_bit_cnt = r_bit_cnt + 1'b1;
        if (r_bit_cnt == CNT_W'(PKT_WIDTH - 1)) begin
          w_done    = 1'b1;
          w_gap_cnt = '0;
          w_next    = GAP;
        end
      end else begin
        // the invalid cycle that broke the packet already counts as idle
        w_ferr    = 1'b1;
        w_gap_cnt = CNT_W'(1);
        w_next    = GAP;
      end
      GAP: if (bus.i_bit_valid) begin
        w_ferr    = 1'b1;
        w_gap_cnt = '0;
      end else begin
        w_gap_cnt = r_gap_cnt + 1'b1;
        w_next    = (w_gap_cnt == CNT_W'(MIN_GAP)) ? IDLE : GAP;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_shift          <= '0;
      r_bit_cnt        <= '0;
      r_gap_cnt        <= '0;
      r_done           <= 1'b0;
      r_full           <= 1'b0;
      r_par_bad        <= 1'b0;
      bus.o_packet     <= '0;
      bus.o_wr_en      <= 1'b0;
      bus.o_rx_active  <= 1'b0;
      bus.o_frame_err  <= 1'b0;
      bus.o_overflow   <= 1'b0;
      bus.o_parity_err <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_shift          <= w_shift;
      r_bit_cnt        <= w_bit_cnt;
      r_gap_cnt        <= w_gap_cnt;
      r_done           <= w_done;
      r_full           <= w_done & bus.i_fifo_full;
      r_par_bad        <= w_done & w_par_bad;
      bus.o_rx_active  <= w_next == RECEIVE;
      bus.o_frame_err  <= w_ferr;
      bus.o_packet     <= r_done ? r_shift : bus.o_packet;
      bus.o_parity_err <= r_done & r_par_bad;
      bus.o_overflow   <= r_done & ~r_par_bad & r_full;
      bus.o_wr_en      <= r_done & ~r_par_bad & ~r_full;
    end
  end
endmodule
